// File: rtl/simple_dpram_sclk.sv
// simple_dpram_sclk: single-clock simple dual-port RAM with registered read and optional write-to-read bypass
module simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter bit ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  if (ADDR_WIDTH <= 0) begin : g_bad_addr
    $error("simple_dpram_sclk: ADDR_WIDTH must be > 0");
  end
  if (DATA_WIDTH <= 0) begin : g_bad_data
    $error("simple_dpram_sclk: DATA_WIDTH must be > 0");
  end
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  byp_q;
  // Memory array kept free of reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (!rst && we) mem[waddr] <= din;
    if (!rst && re) mem_q <= mem[raddr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q <= 1'b0;
      din_q <= '0;
    end else if (re) begin
      byp_q <= ENABLE_BYPASS && we && (raddr == waddr);
      din_q <= din;
    end
  end
  // Read register is cleared separately from the array write so reset never blocks writes' inference
  logic rst_q;
  always_ff @(posedge clk) rst_q <= rst ? 1'b1 : (re ? 1'b0 : rst_q);
  always_comb dout = rst_q ? '0 : (byp_q ? din_q : mem_q);
endmodule

// File: tb/tb_simple_dpram_sclk.sv
// tb_simple_dpram_sclk: directed checks of bypass-on and bypass-off instances driven in parallel
module tb_simple_dpram_sclk;
  logic        clk = 1'b0;
  logic        rst, re, we;
  logic [3:0]  raddr, waddr;
  logic [31:0] din;
  logic [31:0] dout_b, dout_n;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  simple_dpram_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ENABLE_BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re), .waddr(waddr), .we(we), .din(din), .dout(dout_b)
  );
  simple_dpram_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ENABLE_BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re), .waddr(waddr), .we(we), .din(din), .dout(dout_n)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic e_r, input logic [3:0] ra,
                       input logic e_w, input logic [3:0] wa, input logic [31:0] d);
    rst = r; re = e_r; raddr = ra; we = e_w; waddr = wa; din = d;
    cyc();
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0);
    chk("reset_b", dout_b, 32'h0);
    chk("reset_n", dout_n, 32'h0);
    drive(0, 0, 0, 1, 3, 32'hDEADBEEF);
    drive(0, 1, 3, 0, 0, 32'h0);
    chk("basic_b", dout_b, 32'hDEADBEEF);
    chk("basic_n", dout_n, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 3, 1, 3, 32'h0);
      chk("hold_b", dout_b, 32'hDEADBEEF);
    end
    drive(0, 1, 3, 0, 0, 32'h0);
    chk("hold_release", dout_b, 32'h0);
    drive(0, 0, 0, 1, 5, 32'h11111111);
    drive(0, 1, 5, 1, 5, 32'h22222222);
    chk("coll_bypass", dout_b, 32'h22222222);
    chk("coll_nobypass", dout_n, 32'h11111111);
    drive(0, 1, 5, 0, 0, 32'h0);
    chk("coll_after_b", dout_b, 32'h22222222);
    chk("coll_after_n", dout_n, 32'h22222222);
    drive(0, 0, 0, 1, 7, 32'h77777777);
    drive(0, 0, 0, 1, 3, 32'hCAFEF00D);
    drive(0, 1, 3, 0, 0, 32'h0);
    chk("pre_rst", dout_b, 32'hCAFEF00D);
    drive(1, 1, 3, 1, 7, 32'hBAD0BAD0);
    chk("rst_b", dout_b, 32'h0);
    chk("rst_n", dout_n, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);
    chk("rst_hold", dout_b, 32'h0);
    drive(0, 1, 7, 0, 0, 32'h0);
    chk("rst_nowrite", dout_b, 32'h77777777);
    drive(0, 1, 3, 0, 0, 32'h0);
    chk("rst_keepmem", dout_n, 32'hCAFEF00D);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 4'(i), 32'(i) * 32'h01010101);
    drive(0, 1, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      chk("sweep_b", dout_b, 32'(i - 1) * 32'h01010101);
      chk("sweep_n", dout_n, 32'(i - 1) * 32'h01010101);
      drive(0, 1, 4'(i % 16), 0, 0, 32'h0);
    end
    chk("sweep_wrap", dout_b, 32'h0);
    drive(0, 1, 2, 1, 4, 32'hA5A5A5A5);
    chk("indep_b", dout_b, 32'h02020202);
    chk("indep_n", dout_n, 32'h02020202);
    drive(0, 1, 4, 0, 0, 32'h0);
    chk("indep_write", dout_b, 32'hA5A5A5A5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
